// File: rtl/mul_sign_ctrl.sv
// Sign-handling and sequencing front end for an unsigned NxN multiplier core (MUL/MULH/MULHSU/MULHU).
// Optional single-entry result cache is compiled in when MUL_RESULT_CACHE_EN is defined.
module mul_sign_ctrl #(
    parameter int N = 32
) (
    input  logic           clk_in,
    input  logic           reset_in,
    input  logic           flush_in,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [N-1:0]   req_rs1,
    input  logic [N-1:0]   req_rs2,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N-1:0]   rsp_data,
    output logic           mult_start,
    output logic           mult_is_signed,
    output logic [N-1:0]   mult_a,
    output logic [N-1:0]   mult_b,
    input  logic           mult_done,
    input  logic [2*N-1:0] mult_result
);

    typedef enum logic [1:0] {IDLE, MULT, FIX, RESP} state_t;

    localparam logic [1:0]     OP_MUL    = 2'b00;
    localparam logic [1:0]     OP_MULH   = 2'b01;
    localparam logic [1:0]     OP_MULHSU = 2'b10;
    localparam logic [N-1:0]   ONE_N     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N    = {{(2*N-1){1'b0}}, 1'b1};

    state_t         state, state_next;
    logic           a_signed, b_signed, neg_a, neg_b, accept, cache_hit;
    logic [N-1:0]   mag_a, mag_b, fix_data, hit_data;
    logic [N-1:0]   mag_a_q, mag_b_q, rsp_data_q;
    logic           neg_p_q;
    logic [1:0]     op_q;
    logic [2*N-1:0] prod_q, prod_fix;

    // Magnitudes of the incoming operands; the most negative value maps onto itself as unsigned.
    always_comb begin
        a_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU);
        b_signed = (req_op == OP_MULH);
        neg_a    = a_signed && req_rs1[N-1];
        neg_b    = b_signed && req_rs2[N-1];
        mag_a    = neg_a ? (~req_rs1 + ONE_N) : req_rs1;
        mag_b    = neg_b ? (~req_rs2 + ONE_N) : req_rs2;
        accept   = (state == IDLE) && req_valid && !flush_in;
    end

    always_comb begin
        prod_fix = neg_p_q ? (~prod_q + ONE_2N) : prod_q;
        fix_data = (op_q == OP_MUL) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
    end

`ifdef MUL_RESULT_CACHE_EN
    logic           cache_valid, cache_as, cache_bs;
    logic [N-1:0]   cache_rs1, cache_rs2, rs1_q, rs2_q;
    logic [2*N-1:0] cache_p;
    logic           as_q, bs_q;

    // A MUL low half does not depend on signedness, so it hits on operand match alone.
    always_comb begin
        cache_hit = cache_valid && (req_rs1 == cache_rs1) && (req_rs2 == cache_rs2) &&
                    ((req_op == OP_MUL) || ((a_signed == cache_as) && (b_signed == cache_bs)));
        hit_data  = (req_op == OP_MUL) ? cache_p[N-1:0] : cache_p[2*N-1:N];
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cache_valid <= 1'b0;
            cache_as    <= 1'b0;
            cache_bs    <= 1'b0;
            cache_rs1   <= '0;
            cache_rs2   <= '0;
            cache_p     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            as_q        <= 1'b0;
            bs_q        <= 1'b0;
        end else begin
            if (accept) begin
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                as_q  <= a_signed;
                bs_q  <= b_signed;
            end
            if ((state == FIX) && !flush_in) begin
                cache_valid <= 1'b1;
                cache_rs1   <= rs1_q;
                cache_rs2   <= rs2_q;
                cache_as    <= as_q;
                cache_bs    <= bs_q;
                cache_p     <= prod_fix;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides every transition and returns to IDLE without a response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = cache_hit ? RESP : MULT;
            MULT:    if (mult_done) state_next = FIX;
            FIX:     state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_in) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            neg_p_q    <= 1'b0;
            op_q       <= OP_MUL;
            prod_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                mag_a_q <= mag_a;
                mag_b_q <= mag_b;
                neg_p_q <= neg_a ^ neg_b;
                op_q    <= req_op;
            end
            if ((state == MULT) && mult_done) begin
                prod_q <= mult_result;
            end
            if (state == FIX) begin
                rsp_data_q <= fix_data;
            end else if (accept && cache_hit) begin
                rsp_data_q <= hit_data;
            end
        end
    end

    always_comb begin
        req_ready      = (state == IDLE);
        rsp_valid      = (state == RESP);
        rsp_data       = rsp_data_q;
        mult_start     = (state == MULT);
        mult_is_signed = 1'b0;
        mult_a         = (state == MULT) ? mag_a_q : '0;
        mult_b         = (state == MULT) ? mag_b_q : '0;
    end

endmodule

// File: tb/tb_mul_sign_ctrl.sv
// Self-checking bench for mul_sign_ctrl: behavioural core stub, arithmetic reference model, randomized traffic.
// Also models the optional MUL_RESULT_CACHE_EN result cache when that macro is defined.
module tb_mul_sign_ctrl;

    localparam int N = 32;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    logic          clk_in = 1'b0;
    logic          reset_in, flush_in, req_valid, rsp_ready, stray_done;
    logic [1:0]    req_op;
    logic [N-1:0]  req_rs1, req_rs2, rsp_data, mult_a, mult_b;
    logic          req_ready, rsp_valid, mult_start, mult_is_signed, mult_done;
    logic [2*N-1:0] mult_result;

    int checks = 0;
    int failures = 0;
    int done_delay = 0;
    int wait_cnt = 0;
    int start_cnt = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_mag_a = '0;
    logic [N-1:0] exp_mag_b = '0;

`ifdef MUL_RESULT_CACHE_EN
    bit          m_cvalid = 1'b0;
    bit          m_as, m_bs;
    logic [31:0] m_c1, m_c2;
`endif

    always #5 clk_in = ~clk_in;

    mul_sign_ctrl #(.N(N)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mult_start(mult_start), .mult_is_signed(mult_is_signed),
        .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_result(mult_result)
    );

    // Behavioural unsigned core: combinational product, done after a programmable number of low cycles.
    assign mult_result = {{N{1'b0}}, mult_a} * {{N{1'b0}}, mult_b};
    assign mult_done   = (mult_start && (wait_cnt >= done_delay)) || stray_done;

    always @(posedge clk_in) begin
        wait_cnt <= (mult_start && !mult_done) ? wait_cnt + 1 : 0;
    end

    function automatic logic [63:0] refProduct(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
        logic signed [65:0] a, b, p;
        a = (op == 2'b01 || op == 2'b10) ? {{34{rs1[31]}}, rs1} : {34'd0, rs1};
        b = (op == 2'b01) ? {{34{rs2[31]}}, rs2} : {34'd0, rs2};
        p = a * b;
        return p[63:0];
    endfunction

    function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
        logic [63:0] p;
        p = refProduct(op, rs1, rs2);
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit modelHit(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
`ifdef MUL_RESULT_CACHE_EN
        bit as, bs;
        as = (op == 2'b01 || op == 2'b10);
        bs = (op == 2'b01);
        return m_cvalid && rs1 == m_c1 && rs2 == m_c2 && (op == 2'b00 || (as == m_as && bs == m_bs));
`else
        return (op == 2'b11) && (rs1 != rs1);
`endif
    endfunction

    task automatic modelFill(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
`ifdef MUL_RESULT_CACHE_EN
        m_cvalid = 1'b1;
        m_c1 = rs1;
        m_c2 = rs2;
        m_as = (op == 2'b01 || op == 2'b10);
        m_bs = (op == 2'b01);
`else
        req_op = op;
`endif
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle checks of the core interface and the response stream against the expected queue.
    always @(negedge clk_in) begin
        if (!reset_in) begin
            checkOutput("mult_is_signed", {63'd0, mult_is_signed}, 64'd0);
            if (mult_start) begin
                start_cnt++;
                checkOutput("mult_a", {32'd0, mult_a}, {32'd0, exp_mag_a});
                checkOutput("mult_b", {32'd0, mult_b}, {32'd0, exp_mag_b});
            end else begin
                checkOutput("mult_a_idle", {32'd0, mult_a}, 64'd0);
                checkOutput("mult_b_idle", {32'd0, mult_b}, 64'd0);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    checkOutput("rsp_data", {32'd0, rsp_data}, {32'd0, exp_q[0]});
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        checkOutput({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        checkOutput({tag, "_rsp_data"}, {32'd0, rsp_data}, 64'd0);
        checkOutput({tag, "_mult_start"}, {63'd0, mult_start}, 64'd0);
        checkOutput({tag, "_mult_a"}, {32'd0, mult_a}, 64'd0);
        checkOutput({tag, "_mult_b"}, {32'd0, mult_b}, 64'd0);
    endtask

    task automatic doReset();
        reset_in = 1'b1;
        step();
        step();
        reset_in = 1'b0;
`ifdef MUL_RESULT_CACHE_EN
        m_cvalid = 1'b0;
`endif
    endtask

    // Presents one request and returns just after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input int delay, output bit hit);
        int guard;
        bit as, bs;
        guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        checkOutput("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
        as = (op == 2'b01 || op == 2'b10);
        bs = (op == 2'b01);
        exp_mag_a = (as && rs1[31]) ? (32'd0 - rs1) : rs1;
        exp_mag_b = (bs && rs2[31]) ? (32'd0 - rs2) : rs2;
        hit = modelHit(op, rs1, rs2);
        done_delay = delay;
        req_op = op;
        req_rs1 = rs1;
        req_rs2 = rs2;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        start_cnt = 0;
    endtask

    task automatic runTxn(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] expected, input int delay, input int stall);
        bit hit;
        int lat;
        applyStimulus(op, rs1, rs2, delay, hit);
        exp_q.push_back(expected);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            step();
            lat++;
        end
        checkOutput("latency", lat, hit ? 64'd1 : 64'(3 + delay));
        checkOutput("start_cycles", start_cnt, hit ? 64'd0 : 64'(1 + delay));
        if (!hit) modelFill(op, rs1, rs2);
        rsp_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            checkOutput("rsp_valid_hold", {63'd0, rsp_valid}, 64'd1);
            checkOutput("req_ready_busy", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("req_ready_after_rsp", {63'd0, req_ready}, 64'd1);
        checkOutput("rsp_valid_after_rsp", {63'd0, rsp_valid}, 64'd0);
        checkOutput("queue_drained", exp_q.size(), 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[$];
        bit hit;
        logic [1:0] op;
        logic [31:0] a, b;

        reset_in = 1'b1;
        flush_in = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        stray_done = 1'b0;
        req_op = 2'b00;
        req_rs1 = '0;
        req_rs2 = '0;
        step();
        step();
        checkResetValues("reset");
        reset_in = 1'b0;

        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001});
        vecs.push_back('{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        foreach (vecs[i]) begin
            checkOutput("model_pin", {32'd0, refResult(vecs[i].op, vecs[i].a, vecs[i].b)}, {32'd0, vecs[i].r});
            runTxn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, 0, 0);
        end

        // Response stall followed by a back-to-back request.
        runTxn(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, refResult(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 2, 5);
        runTxn(2'b00, 32'h0000_BEEF, 32'h0000_0101, refResult(2'b00, 32'h0000_BEEF, 32'h0000_0101), 1, 0);

        // Flush while the core is busy.
        applyStimulus(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 10, hit);
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        checkOutput("flush_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("flush_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("flush_mult_start", {63'd0, mult_start}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("flush_quiet", {63'd0, rsp_valid}, 64'd0);
        end
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        checkOutput("stray_done_idle", {63'd0, req_ready}, 64'd1);
        checkOutput("stray_done_start", {63'd0, mult_start}, 64'd0);
        flush_in = 1'b1;
        req_valid = 1'b1;
        req_op = 2'b00;
        req_rs1 = 32'h55;
        req_rs2 = 32'h66;
        step();
        flush_in = 1'b0;
        req_valid = 1'b0;
        checkOutput("flushed_req_ignored", {63'd0, req_ready}, 64'd1);
        checkOutput("flushed_req_start", {63'd0, mult_start}, 64'd0);

        // Reset while in FIX.
        applyStimulus(2'b00, 32'h0000_1234, 32'h0000_5678, 0, hit);
        step();
        reset_in = 1'b1;
        step();
        checkResetValues("reset_fix");
        reset_in = 1'b0;
`ifdef MUL_RESULT_CACHE_EN
        m_cvalid = 1'b0;
`endif

        // Same-operand pair, then repeated after reset.
        for (int k = 0; k < 2; k++) begin
            runTxn(2'b01, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0);
            runTxn(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0);
            doReset();
        end

        a = 32'h1;
        b = 32'h1;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                a = pickOperand();
                b = pickOperand();
            end
            runTxn(op, a, b, refResult(op, a, b), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
